// File: rtl/chess_pkg.sv
// Shared piece encodings, result codes and FSM states for the move-check requester.
package chess_pkg;

  localparam logic [2:0] EMPTY  = 3'd0;
  localparam logic [2:0] PAWN   = 3'd1;
  localparam logic [2:0] KNIGHT = 3'd2;
  localparam logic [2:0] BISHOP = 3'd3;
  localparam logic [2:0] ROOK   = 3'd4;
  localparam logic [2:0] QUEEN  = 3'd5;
  localparam logic [2:0] KING   = 3'd6;
  localparam int         COLOR_BIT = 3;

  typedef enum logic [2:0] {
    RC_OK         = 3'd0,
    RC_EMPTY_SRC  = 3'd1,
    RC_WRONG_TURN = 3'd2,
    RC_OWN_DEST   = 3'd3,
    RC_NULL_MOVE  = 3'd4,
    RC_BLOCKED    = 3'd5,
    RC_ILLEGAL    = 3'd6,
    RC_TIMEOUT    = 3'd7
  } rsp_code_t;

  typedef enum logic [2:0] {
    S_IDLE, S_PRECHECK, S_PATH, S_CHK_WAIT, S_RESP
  } mci_state_t;

  function automatic logic is_sliding(input logic [2:0] kind);
    return (kind == BISHOP) || (kind == ROOK) || (kind == QUEEN);
  endfunction

  function automatic logic [2:0] absdiff3(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/path_stepper.sv
// Step direction, cursor advance and line/diagonal geometry for the path scan.
module path_stepper
  import chess_pkg::*;
(
  input  logic [2:0] src_x_i,
  input  logic [2:0] src_y_i,
  input  logic [2:0] dst_x_i,
  input  logic [2:0] dst_y_i,
  input  logic [2:0] cur_x_i,
  input  logic [2:0] cur_y_i,
  output logic [2:0] start_x_o,
  output logic [2:0] start_y_o,
  output logic [2:0] next_x_o,
  output logic [2:0] next_y_o,
  output logic       next_at_dst_o,
  output logic       line_o,
  output logic       diag_o
);

  logic [2:0] step_x, step_y;

  // -1 is 3'b111; 3-bit wrap-around add gives the signed step
  always_comb begin
    step_x = 3'd0;
    step_y = 3'd0;
    if (dst_x_i > src_x_i)      step_x = 3'd1;
    else if (dst_x_i < src_x_i) step_x = 3'b111;
    if (dst_y_i > src_y_i)      step_y = 3'd1;
    else if (dst_y_i < src_y_i) step_y = 3'b111;
  end

  assign start_x_o     = src_x_i + step_x;
  assign start_y_o     = src_y_i + step_y;
  assign next_x_o      = cur_x_i + step_x;
  assign next_y_o      = cur_y_i + step_y;
  assign next_at_dst_o = (next_x_o == dst_x_i) && (next_y_o == dst_y_i);
  assign line_o        = (src_x_i == dst_x_i) || (src_y_i == dst_y_i);
  assign diag_o        = absdiff3(src_x_i, dst_x_i) == absdiff3(src_y_i, dst_y_i);

endmodule

// File: rtl/move_check_initiator.sv
// Requester side of the piece-checker protocol: pre-checks, path scan,
// checker restart/verdict collection and coded response.
module move_check_initiator
  import chess_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
)(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_old_x,
  input  logic [2:0]            req_old_y,
  input  logic [2:0]            req_new_x,
  input  logic [2:0]            req_new_y,
  input  logic                  turn_black,
  input  logic [7:0][7:0][3:0]  board_in,
  output logic                  chk_reset_n,
  output logic [2:0]            chk_old_x,
  output logic [2:0]            chk_old_y,
  output logic [2:0]            chk_new_x,
  output logic [2:0]            chk_new_y,
  output logic [2:0]            chk_h_delta,
  output logic [2:0]            chk_v_delta,
  output logic [3:0]            chk_piece_type,
  input  logic                  chk_valid_move,
  input  logic                  chk_valid_output,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_legal,
  output logic [2:0]            rsp_code
);

  mci_state_t state_q, state_d;
  logic [2:0] old_x_q, old_y_q, new_x_q, new_y_q, hd_q, vd_q;
  logic [3:0] piece_q, dst_q;
  logic       turn_q;
  logic [2:0] cur_x_q, cur_y_q, cur_x_d, cur_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       flag_q, flag_d, flag_now;
  logic       legal_q, legal_d;
  rsp_code_t  code_q, code_d;

  logic [2:0] start_x, start_y, next_x, next_y;
  logic       next_at_dst, on_line, on_diag, accept, cur_occ;

  path_stepper u_step (
    .src_x_i(old_x_q), .src_y_i(old_y_q),
    .dst_x_i(new_x_q), .dst_y_i(new_y_q),
    .cur_x_i(cur_x_q), .cur_y_i(cur_y_q),
    .start_x_o(start_x), .start_y_o(start_y),
    .next_x_o(next_x), .next_y_o(next_y),
    .next_at_dst_o(next_at_dst), .line_o(on_line), .diag_o(on_diag)
  );

  assign accept   = (state_q == S_IDLE) && req_valid;
  assign cur_occ  = board_in[cur_x_q][cur_y_q][2:0] != EMPTY;
  assign flag_now = flag_q | chk_valid_move;

  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    legal_d = legal_q;
    code_d  = code_q;
    unique case (state_q)
      S_IDLE: if (req_valid) state_d = S_PRECHECK;
      S_PRECHECK: begin
        legal_d = 1'b0;
        state_d = S_RESP;
        if ((old_x_q == new_x_q) && (old_y_q == new_y_q))
          code_d = RC_NULL_MOVE;
        else if (piece_q[2:0] == EMPTY)
          code_d = RC_EMPTY_SRC;
        else if (piece_q[COLOR_BIT] != turn_q)
          code_d = RC_WRONG_TURN;
        else if ((dst_q[2:0] != EMPTY) && (dst_q[COLOR_BIT] == piece_q[COLOR_BIT]))
          code_d = RC_OWN_DEST;
        else if (is_sliding(piece_q[2:0]) && (on_line || on_diag) &&
                 ((hd_q > 3'd1) || (vd_q > 3'd1))) begin
          state_d = S_PATH;
          cur_x_d = start_x;
          cur_y_d = start_y;
        end else begin
          state_d = S_CHK_WAIT;
          cnt_d   = '0;
          flag_d  = 1'b0;
        end
      end
      S_PATH: begin
        if (cur_occ) begin
          code_d  = RC_BLOCKED;
          state_d = S_RESP;
        end else if (next_at_dst) begin
          state_d = S_CHK_WAIT;
          cnt_d   = '0;
          flag_d  = 1'b0;
        end else begin
          cur_x_d = next_x;
          cur_y_d = next_y;
        end
      end
      S_CHK_WAIT: begin
        flag_d = flag_now;
        cnt_d  = cnt_q + 1'b1;
        // a verdict in the last allowed cycle wins over the timeout
        if (chk_valid_output) begin
          legal_d = flag_now;
          code_d  = flag_now ? RC_OK : RC_ILLEGAL;
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          code_d  = RC_TIMEOUT;
          state_d = S_RESP;
        end
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      old_x_q <= '0; old_y_q <= '0; new_x_q <= '0; new_y_q <= '0;
      hd_q    <= '0; vd_q    <= '0;
      piece_q <= '0; dst_q   <= '0; turn_q  <= 1'b0;
      cur_x_q <= '0; cur_y_q <= '0; cnt_q   <= '0;
      flag_q  <= 1'b0; legal_q <= 1'b0; code_q <= RC_OK;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      legal_q <= legal_d;
      code_q  <= code_d;
      if (accept) begin
        old_x_q <= req_old_x;
        old_y_q <= req_old_y;
        new_x_q <= req_new_x;
        new_y_q <= req_new_y;
        hd_q    <= absdiff3(req_old_x, req_new_x);
        vd_q    <= absdiff3(req_old_y, req_new_y);
        piece_q <= board_in[req_old_x][req_old_y];
        dst_q   <= board_in[req_new_x][req_new_y];
        turn_q  <= turn_black;
      end
    end
  end

  // checker is held in reset everywhere except CHK_WAIT
  assign req_ready      = (state_q == S_IDLE);
  assign rsp_valid      = (state_q == S_RESP);
  assign chk_reset_n    = (state_q == S_CHK_WAIT);
  assign rsp_legal      = legal_q;
  assign rsp_code       = code_q;
  assign chk_old_x      = old_x_q;
  assign chk_old_y      = old_y_q;
  assign chk_new_x      = new_x_q;
  assign chk_new_y      = new_y_q;
  assign chk_h_delta    = hd_q;
  assign chk_v_delta    = vd_q;
  assign chk_piece_type = piece_q;

endmodule

// File: tb/tb_move_check_initiator.sv
// Directed plus randomized bench for move_check_initiator against a rule-level model.
module tb_move_check_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, req_valid, req_ready, turn_black;
  logic [2:0]  req_old_x, req_old_y, req_new_x, req_new_y;
  logic [7:0][7:0][3:0] board;
  logic        chk_reset_n, chk_valid_move, chk_valid_output;
  logic [2:0]  chk_old_x, chk_old_y, chk_new_x, chk_new_y, chk_h_delta, chk_v_delta;
  logic [3:0]  chk_piece_type;
  logic        rsp_valid, rsp_ready, rsp_legal;
  logic [2:0]  rsp_code;

  int n_cmp = 0, n_fail = 0;
  int mv_cyc = 0, out_cyc = 0, rel_cnt = 0;

  move_check_initiator #(.TIMEOUT_CYCLES(15), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_old_x(req_old_x), .req_old_y(req_old_y),
    .req_new_x(req_new_x), .req_new_y(req_new_y),
    .turn_black(turn_black), .board_in(board),
    .chk_reset_n(chk_reset_n),
    .chk_old_x(chk_old_x), .chk_old_y(chk_old_y),
    .chk_new_x(chk_new_x), .chk_new_y(chk_new_y),
    .chk_h_delta(chk_h_delta), .chk_v_delta(chk_v_delta),
    .chk_piece_type(chk_piece_type),
    .chk_valid_move(chk_valid_move), .chk_valid_output(chk_valid_output),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_legal(rsp_legal), .rsp_code(rsp_code)
  );

  // checker stub: counts released cycles, 1-based
  always @(posedge clk) rel_cnt <= chk_reset_n ? rel_cnt + 1 : 0;
  assign chk_valid_move   = chk_reset_n && (rel_cnt + 1 == mv_cyc);
  assign chk_valid_output = chk_reset_n && (out_cyc != 0) && (rel_cnt + 1 >= out_cyc);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct { int code; int legal; int lat; int rel; } exp_t;

  // Reference: rule-by-rule evaluation; lat = cycles from accept to rsp_valid
  function automatic exp_t model(int ox, int oy, int nx, int ny, int turn, int mv, int oc);
    exp_t e;
    logic [3:0] src, dst;
    int dx, dy, adx, ady, sx, sy, x, y, k, blk, kind;
    src = board[ox][oy];
    dst = board[nx][ny];
    dx = nx - ox; dy = ny - oy;
    adx = dx < 0 ? -dx : dx; ady = dy < 0 ? -dy : dy;
    kind = int'(src[2:0]);
    e.legal = 0; e.rel = 0; e.lat = 2;
    if (dx == 0 && dy == 0) e.code = 4;
    else if (kind == 0) e.code = 1;
    else if (int'(src[3]) != turn) e.code = 2;
    else if (dst[2:0] != 3'd0 && dst[3] == src[3]) e.code = 3;
    else begin
      k = 0; blk = 0;
      if (kind >= 3 && kind <= 5 && (dx == 0 || dy == 0 || adx == ady) && (adx > 1 || ady > 1)) begin
        sx = dx > 0 ? 1 : (dx < 0 ? -1 : 0);
        sy = dy > 0 ? 1 : (dy < 0 ? -1 : 0);
        x = ox + sx; y = oy + sy;
        while (!(x == nx && y == ny) && blk == 0) begin
          k++;
          if (board[x][y][2:0] != 3'd0) blk = 1;
          x += sx; y += sy;
        end
      end
      if (blk != 0) begin
        e.code = 5; e.lat = 2 + k;
      end else begin
        e.rel = 1;
        if (oc >= 1 && oc <= 15) begin
          e.legal = (mv >= 1 && mv <= oc) ? 1 : 0;
          e.code  = e.legal != 0 ? 0 : 6;
          e.lat   = 2 + k + oc;
        end else begin
          e.code = 7; e.lat = 2 + k + 15;
        end
      end
    end
    return e;
  endfunction

  task automatic do_move(input int ox, input int oy, input int nx, input int ny,
                         input int turn, input int mv, input int oc, input int hold);
    exp_t e;
    int n, saw_rel, adx, ady;
    e = model(ox, oy, nx, ny, turn, mv, oc);
    mv_cyc = mv; out_cyc = oc;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 1);
    req_old_x = 3'(ox); req_old_y = 3'(oy);
    req_new_x = 3'(nx); req_new_y = 3'(ny);
    turn_black = turn[0]; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_old_x = 3'($urandom); req_new_y = 3'($urandom); turn_black = ~turn_black;
    adx = nx > ox ? nx - ox : ox - nx;
    ady = ny > oy ? ny - oy : oy - ny;
    check("chk_old_x", 32'(chk_old_x), 32'(ox));
    check("chk_new_y", 32'(chk_new_y), 32'(ny));
    check("chk_h_delta", 32'(chk_h_delta), 32'(adx));
    check("chk_v_delta", 32'(chk_v_delta), 32'(ady));
    check("chk_piece", 32'(chk_piece_type), 32'(board[ox][oy]));
    n = 1; saw_rel = 0;
    while (!rsp_valid && n < 60) begin
      if (chk_reset_n) saw_rel = 1;
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(e.lat));
    check("rsp_code", 32'(rsp_code), 32'(e.code));
    check("rsp_legal", 32'(rsp_legal), 32'(e.legal));
    check("chk_released", 32'(saw_rel), 32'(e.rel));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_hold_valid", 32'(rsp_valid), 1);
      check("rsp_hold_code", 32'(rsp_code), 32'(e.code));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("idle_after_rsp", 32'({req_ready, rsp_valid}), 32'(2'b10));
  endtask

  initial begin
    int ox, oy, nx, ny, d, turn, mode;
    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; turn_black = 1'b0;
    req_old_x = '0; req_old_y = '0; req_new_x = '0; req_new_y = '0;
    board = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_legal", 32'(rsp_legal), 0);
    check("rst_rsp_code", 32'(rsp_code), 0);
    check("rst_chk_reset_n", 32'(chk_reset_n), 0);
    check("rst_chk_data", 32'({chk_old_x, chk_new_y, chk_h_delta, chk_piece_type}), 0);
    reset_n = 1'b1;

    // queen slide with clear path, then blocked by a pawn
    board[3][0] = 4'h5;
    do_move(3, 0, 3, 4, 0, 2, 3, 0);
    board[3][2] = 4'h1;
    do_move(3, 0, 3, 4, 0, 2, 3, 2);
    // precheck failures
    board = '0;
    do_move(0, 0, 0, 1, 0, 2, 3, 0);
    do_move(1, 1, 2, 2, 0, 2, 3, 0);
    board[0][0] = 4'h4;
    do_move(0, 0, 0, 3, 1, 2, 3, 0);
    board[0][0] = 4'h9; board[1][1] = 4'hA;
    do_move(0, 0, 1, 1, 1, 2, 3, 0);
    board[0][0] = 4'h5;
    do_move(0, 0, 0, 0, 0, 2, 3, 0);
    // knight: checker never finishes, response held, then checker says illegal
    board = '0; board[0][0] = 4'h2;
    do_move(0, 0, 1, 2, 0, 0, 0, 5);
    do_move(0, 0, 1, 2, 0, 0, 1, 0);
    do_move(0, 0, 1, 2, 0, 1, 1, 0);

    // reset while scanning the path
    board = '0; board[0][0] = 4'h5; mv_cyc = 2; out_cyc = 3;
    @(negedge clk);
    req_old_x = 3'd0; req_old_y = 3'd0; req_new_x = 3'd0; req_new_y = 3'd7;
    turn_black = 1'b0; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_req_ready", 32'(req_ready), 1);
    check("midrst_rsp_valid", 32'(rsp_valid), 0);
    check("midrst_chk_reset_n", 32'(chk_reset_n), 0);
    check("midrst_chk_piece", 32'(chk_piece_type), 0);
    @(negedge clk); reset_n = 1'b1;
    do_move(0, 0, 0, 7, 0, 2, 3, 1);

    // randomized boards and moves
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++)
          board[i][j] = ($urandom % 10 < 3) ? {1'($urandom), 3'($urandom_range(1, 6))} : 4'h0;
      turn = int'($urandom % 2);
      mode = int'($urandom % 3);
      ox = int'($urandom % 8); oy = int'($urandom % 8);
      nx = int'($urandom % 8); ny = int'($urandom % 8);
      if (mode == 1) ny = oy;
      if (mode == 2) begin
        ox = int'($urandom % 4); oy = int'($urandom % 4);
        d = int'($urandom_range(1, 4));
        nx = ox + d; ny = oy + d;
      end
      if ($urandom % 4 != 0)
        board[ox][oy] = {turn[0], 3'($urandom_range(3, 5))};
      do_move(ox, oy, nx, ny, turn, int'($urandom % 5), int'($urandom % 6), int'($urandom % 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
